// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port-B arbiter: default widths, owner
// encoding, FSM state encoding and the read-return tag carried alongside
// each issued command.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 14;
  localparam int DEF_DW = 18;
  localparam int DEF_CW = 16;

  // Owner encoding shown on the owner output.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  // Arbiter FSM states; the lock states exist only with ARB_LOCK_EN.
  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  // Read-return tag: valid marks a read in flight, id names the issuer.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // Build the tag for a command; writes never return data.
  function automatic rd_tag_t make_tag(input logic issued, input logic we,
                                       input logic id);
    rd_tag_t t;
    t.valid = issued & ~we;
    t.id    = id;
    return t;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker. On a tie the port that did not
// win last time is chosen; a lone request always wins.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_winner_i,  // 0 = port 0 won last tie, 1 = port 1
  output logic grant0_o,
  output logic grant1_o
);

  // Grant port 0 when alone, or on a tie when port 1 won last.
  assign grant0_o = req0_i & (~req1_i | last_winner_i);
  // Grant port 1 when alone, or on a tie when port 0 won last.
  assign grant1_o = req1_i & (~req0_i | ~last_winner_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing RAM port B between the CPU controller (m0)
// and an auxiliary engine (m1). Requests sampled at a rising edge are
// registered onto mem_* with a one-cycle gnt pulse; read data returns one
// cycle later with rvalid steered by a pipelined issuer tag.
// Optional feature: define ARB_LOCK_EN to add m0_lock/m1_lock, which let a
// granted port hold the RAM exclusively for read-modify-write sequences.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
`ifdef ARB_LOCK_EN
  input  logic          m0_lock,
`endif
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
`ifdef ARB_LOCK_EN
  input  logic          m1_lock,
`endif
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic [CW-1:0] conflict_cnt
);

  // Command stage registers (the value on mem_* this cycle).
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    owner_q, owner_d;
  rd_tag_t       tag_q, tag_d;

  // Read-return stage: tag aligned with mem_rdata.
  rd_tag_t       rtag_q;

  // Arbitration history and statistics.
  logic          last_q, last_d;     // 0 = m0 won last tie, 1 = m1
  logic [CW-1:0] cnt_q, cnt_d;
  logic          conflict;

  logic          pick0, pick1;

  rr_pick2 u_pick (
    .req0_i        (m0_req),
    .req1_i        (m1_req),
    .last_winner_i (last_q),
    .grant0_o      (pick0),
    .grant1_o      (pick1)
  );

`ifdef ARB_LOCK_EN
  arb_state_e state_q, state_d;
  logic       lock0_act, lock1_act;

  // FSM state register; reset always returns to plain arbitration.
  always_ff @(posedge CLK) begin
    if (!CLR) state_q <= ST_ARB;
    else      state_q <= state_d;
  end
`endif

  // Next-state and grant decision: round-robin, or exclusive while locked.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    conflict = 1'b0;
    last_d   = last_q;
`ifdef ARB_LOCK_EN
    // A lock is taken by a port asserting lock in its gnt cycle and kept
    // while it holds lock; it drops at the first edge lock is seen low.
    lock0_act = m0_lock & ((state_q == ST_LOCK0) | ((state_q == ST_ARB) & gnt0_q));
    lock1_act = m1_lock & ((state_q == ST_LOCK1) | ((state_q == ST_ARB) & gnt1_q));
    state_d   = ST_ARB;
    if (lock0_act) begin
      state_d  = ST_LOCK0;
      gnt0_d   = m0_req;
      conflict = m1_req;  // m1 stalls; every stalled cycle is counted
    end else if (lock1_act) begin
      state_d  = ST_LOCK1;
      gnt1_d   = m1_req;
      conflict = m0_req;
    end else begin
`endif
      gnt0_d   = pick0;
      gnt1_d   = pick1;
      conflict = m0_req & m1_req;
      // History only moves on a tie; a lone request leaves it alone.
      if (conflict) last_d = pick1;
`ifdef ARB_LOCK_EN
    end
`endif
  end

  // Command mux: load the winner, otherwise hold address/data with we low.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = OWN_NONE;
    tag_d   = make_tag(1'b0, 1'b0, 1'b0);
    if (gnt0_d) begin
      we_d    = m0_we;
      addr_d  = m0_addr;
      wdata_d = m0_wdata;
      owner_d = OWN_M0;
      tag_d   = make_tag(1'b1, m0_we, 1'b0);
    end else if (gnt1_d) begin
      we_d    = m1_we;
      addr_d  = m1_addr;
      wdata_d = m1_wdata;
      owner_d = OWN_M1;
      tag_d   = make_tag(1'b1, m1_we, 1'b1);
    end
    // Saturating counter: sticks at all-ones instead of wrapping.
    cnt_d = (conflict && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
  end

  // Command, tag pipeline and statistics registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!CLR) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= OWN_NONE;
      tag_q   <= '0;
      rtag_q  <= '0;     // discards any read in flight
      last_q  <= 1'b1;   // m0 wins the first tie
      cnt_q   <= '0;
    end else begin
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      tag_q   <= tag_d;
      rtag_q  <= tag_q;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m0_gnt       = gnt0_q;
  assign m1_gnt       = gnt1_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign owner        = owner_q;
  assign conflict_cnt = cnt_q;

  // Read data is steered by the returning tag and zero when not valid.
  assign m0_rvalid = rtag_q.valid & ~rtag_q.id;
  assign m1_rvalid = rtag_q.valid &  rtag_q.id;
  assign m0_rdata  = {DW{m0_rvalid}} & mem_rdata;
  assign m1_rdata  = {DW{m1_rvalid}} & mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single read, collision,
// sustained contention, counter saturation (second instance with CW=4)
// and reset with a read in flight. A write-first synchronous RAM model
// sits on port B.
module tb_mem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 18;

  logic          CLK = 1'b0;
  logic          CLR;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    owner;
  logic [15:0]   conflict_cnt;

  // Outputs of the narrow-counter instance.
  logic          s_m0_gnt, s_m0_rvalid, s_m1_gnt, s_m1_rvalid, s_mem_we;
  logic [DW-1:0] s_m0_rdata, s_m1_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;
  logic [1:0]    s_owner;
  logic [3:0]    s_conflict_cnt;

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter dut (
    .CLK(CLK), .CLR(CLR),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .conflict_cnt(conflict_cnt)
  );

  mem_port_arbiter #(.CW(4)) dut_sat (
    .CLK(CLK), .CLR(CLR),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(s_m0_gnt), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(s_m1_gnt), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .owner(s_owner), .conflict_cnt(s_conflict_cnt)
  );

  // Write-first synchronous RAM, one cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_reqs();
    m0_req = 1'b0;
    m1_req = 1'b0;
    m0_we  = 1'b0;
    m1_we  = 1'b0;
  endtask

  initial begin
    ram[16'h0010] = 18'h2ABCD;
    ram[16'h0005] = 18'h3FFFF;
    CLR      = 1'b0;
    m0_req   = 1'b1;  m0_we = 1'b1;  m0_addr = 14'h0123;  m0_wdata = 18'h1;
    m1_req   = 1'b1;  m1_we = 1'b0;  m1_addr = 14'h0456;  m1_wdata = 18'h2;

    // Reset held three cycles with both requesting.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_gnt",    {m0_gnt, m1_gnt},       2'b00);
      check("rst_we",     mem_we,                 1'b0);
      check("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      check("rst_cnt",    conflict_cnt,           16'd0);
      check("rst_owner",  owner,                  2'd0);
    end
    idle_reqs();
    CLR = 1'b1;
    step();
    check("idle_gnt", {m0_gnt, m1_gnt}, 2'b00);

    // Single read by m0.
    m0_req = 1'b1;  m0_we = 1'b0;  m0_addr = 14'h0010;
    step();
    check("rd_gnt0",   m0_gnt,   1'b1);
    check("rd_gnt1",   m1_gnt,   1'b0);
    check("rd_addr",   mem_addr, 14'h0010);
    check("rd_we",     mem_we,   1'b0);
    check("rd_owner",  owner,    2'd1);
    m0_req = 1'b0;
    step();
    check("rd_rvalid0", m0_rvalid, 1'b1);
    check("rd_rdata0",  m0_rdata,  18'h2ABCD);
    check("rd_m1_out",  {m1_gnt, m1_rvalid, m1_rdata}, 20'h0);
    check("rd_gnt_off", m0_gnt,    1'b0);
    check("rd_owner0",  owner,     2'd0);
    check("idle_hold",  mem_addr,  14'h0010);
    check("idle_we",    mem_we,    1'b0);
    step();
    check("rd_rvalid_off", m0_rvalid, 1'b0);

    // Collision: m0 writes 0x0005, m1 reads 0x0005 on the same edge.
    m0_req = 1'b1;  m0_we = 1'b1;  m0_addr = 14'h0005;  m0_wdata = 18'h00111;
    m1_req = 1'b1;  m1_we = 1'b0;  m1_addr = 14'h0005;
    step();
    check("col_gnt",   {m0_gnt, m1_gnt}, 2'b10);
    check("col_we",    mem_we,    1'b1);
    check("col_addr",  mem_addr,  14'h0005);
    check("col_wdata", mem_wdata, 18'h00111);
    check("col_owner", owner,     2'd1);
    check("col_cnt",   conflict_cnt, 16'd1);
    m0_req = 1'b0;
    step();
    check("col_gnt2",   {m0_gnt, m1_gnt}, 2'b01);
    check("col_we2",    mem_we,    1'b0);
    check("col_owner2", owner,     2'd2);
    check("col_wr_norv", m0_rvalid, 1'b0);
    m1_req = 1'b0;
    step();
    check("col_rvalid1", m1_rvalid, 1'b1);
    check("col_rdata1",  m1_rdata,  18'h00111);
    check("col_rvalid0", m0_rvalid, 1'b0);
    check("col_cnt2",    conflict_cnt, 16'd1);

    // Sustained contention after a fresh reset: ten alternating grants.
    CLR = 1'b0;
    step();
    CLR = 1'b1;
    m0_req = 1'b1;  m0_we = 1'b0;  m0_addr = 14'h0010;
    m1_req = 1'b1;  m1_we = 1'b0;  m1_addr = 14'h0005;
    begin
      int n0, n1;
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        n0 += int'(m0_gnt);
        n1 += int'(m1_gnt);
        check("sus_gnt", {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
        if (i > 0) begin
          check("sus_rvalid", {m0_rvalid, m1_rvalid},
                (i % 2 == 1) ? 2'b10 : 2'b01);
          check("sus_rdata", (i % 2 == 1) ? m0_rdata : m1_rdata,
                (i % 2 == 1) ? 18'h2ABCD : 18'h00111);
        end
      end
      idle_reqs();
      step();
      check("sus_last_rv", {m0_rvalid, m1_rvalid}, 2'b01);
      check("sus_last_rd", m1_rdata, 18'h00111);
      check("sus_cnt",     conflict_cnt, 16'd10);
      check("sus_n0",      n0, 5);
      check("sus_n1",      n1, 5);
    end

    // Saturation: twenty conflicting cycles; the 4-bit counter stops at 15.
    CLR = 1'b0;
    step();
    CLR = 1'b1;
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 14) check("sat_at15", s_conflict_cnt, 4'd15);
    end
    check("sat_cnt4",  s_conflict_cnt, 4'd15);
    check("sat_cnt16", conflict_cnt,   16'd20);
    idle_reqs();
    step();
    step();
    check("sat_hold", s_conflict_cnt, 4'd15);

    // Reset while an m1 read is in flight: its rvalid must never appear.
    m1_req = 1'b1;  m1_we = 1'b0;  m1_addr = 14'h0005;
    step();
    check("mid_gnt1", m1_gnt, 1'b1);
    m1_req = 1'b0;
    CLR    = 1'b0;
    step();
    check("mid_rv_a", m1_rvalid, 1'b0);
    check("mid_cnt",  conflict_cnt, 16'd0);
    CLR = 1'b1;
    step();
    check("mid_rv_b", m1_rvalid, 1'b0);
    m0_req = 1'b1;
    m1_req = 1'b1;
    step();
    check("mid_tie", {m0_gnt, m1_gnt}, 2'b10);
    check("mid_tie_cnt", conflict_cnt, 16'd1);
    idle_reqs();
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
